// File: rtl/instruction_fetch_unit_if.sv
// Bundles the fetch unit's two buses: the read port to instruction_memory_mod
// and the opcode valid/ready handshake with the execute unit.
interface instruction_fetch_unit_if;
    logic [7:0] addr;
    logic [7:0] instruction;
    logic       z_flag;
    logic [7:0] opcode_out;
    logic       opcode_valid;
    logic       opcode_ready;

    modport master (
        output addr,
        output opcode_out,
        output opcode_valid,
        input  instruction,
        input  z_flag,
        input  opcode_ready
    );

    modport slave (
        input  addr,
        input  opcode_out,
        input  opcode_valid,
        output instruction,
        output z_flag,
        output opcode_ready
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Per-core fetch sequencer: owns the PC, hides the memory's one-cycle read latency,
// resolves END/JUMNZ locally and hands every other opcode to the execute unit.
module instruction_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'd0,
    parameter logic [7:0] OP_END   = 8'd38,
    parameter logic [7:0] OP_JUMNZ = 8'd40
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    instruction_fetch_unit_if.master   bus,
    output logic [7:0]                 pc_out,
    output logic                       busy,
    output logic                       halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_JWAIT,
        S_JUMP,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] opcode_q, opcode_d;
    logic       valid_q, valid_d;

    logic [7:0] pc_plus1;
    logic [7:0] pc_plus2;

    // 8-bit adders wrap naturally, giving modulo-256 PC arithmetic.
    assign pc_plus1 = pc_q + 8'd1;
    assign pc_plus2 = pc_q + 8'd2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            opcode_q <= 8'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            opcode_q <= opcode_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        opcode_d = opcode_q;
        valid_d  = valid_q;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_d    = RESET_PC;
                    addr_d  = RESET_PC;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (bus.instruction == OP_END) begin
                    if (bus.z_flag) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_plus1;
                        addr_d  = pc_plus1;
                        state_d = S_FETCH;
                    end
                end else if (bus.instruction == OP_JUMNZ) begin
                    // PC stays on the JUMNZ; only the read address moves to the operand.
                    addr_d  = pc_plus1;
                    state_d = S_JWAIT;
                end else begin
                    opcode_d = bus.instruction;
                    valid_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (valid_q && bus.opcode_ready) begin
                    valid_d = 1'b0;
                    pc_d    = pc_plus1;
                    addr_d  = pc_plus1;
                    state_d = S_FETCH;
                end
            end

            S_JWAIT: begin
                state_d = S_JUMP;
            end

            S_JUMP: begin
                // The operand byte is consumed here and never decoded as an opcode.
                if (!bus.z_flag) begin
                    pc_d   = bus.instruction;
                    addr_d = bus.instruction;
                end else begin
                    pc_d   = pc_plus2;
                    addr_d = pc_plus2;
                end
                state_d = S_FETCH;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.addr         = addr_q;
    assign bus.opcode_out   = opcode_q;
    assign bus.opcode_valid = valid_q;
    assign pc_out           = pc_q;
    assign busy             = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted           = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: registered memory model, scoreboard of issued
// opcodes, a table of single-instruction vectors and hand-written multi-cycle sequences.
module tb_instruction_fetch_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] pc_out;
    logic       busy;
    logic       halted;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit dut (
        .clock  (clk),
        .reset  (rst),
        .start  (start),
        .bus    (bus),
        .pc_out (pc_out),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    int         cyc = 0;
    int         start_cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q [$];
    int         stamp_q [$];

    always @(posedge clk) bus.instruction <= ram[bus.addr];
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] op;
        logic [7:0] operand;
        logic       z;
        int         cycles;
        logic [7:0] exp_addr;
        logic       exp_issue;
        logic       exp_halt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted handshake must match the oldest expected opcode.
    always @(negedge clk) begin
        if (!rst && bus.opcode_valid && bus.opcode_ready) begin
            stamp_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", {24'd0, bus.opcode_out}, 32'hFFFF_FFFF);
            end else begin
                chk("issued_opcode", {24'd0, bus.opcode_out}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic fill_ram(input logic [7:0] val);
        for (int a = 0; a < 256; a++) ram[a] = val;
    endtask

    task automatic wait_halt(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string name, input logic [7:0] op, input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.opcode_valid && bus.opcode_out == op) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    // Places one instruction at v.pc (reached via a boot JUMNZ unless pc==0) and checks its effect.
    task automatic run_vec(input vec_t v, input int idx);
        bit ok;
        string tag;
        tag = $sformatf("vec%0d", idx);
        rst = 1'b1;
        fill_ram(8'd1);
        if (v.pc != 8'd0) begin
            ram[0] = 8'd40;
            ram[1] = v.pc;
        end
        ram[v.pc] = v.op;
        if (v.pc != 8'd255) ram[v.pc + 8'd1] = v.operand;
        bus.z_flag = 1'b0;
        bus.opcode_ready = 1'b1;
        exp_q.delete();
        if (v.exp_issue) exp_q.push_back(v.op);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy && pc_out == v.pc && bus.addr == v.pc) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_reach"}, {31'd0, ok}, 32'd1);
        bus.z_flag = v.z;
        repeat (v.cycles) @(posedge clk);
        @(negedge clk);
        chk({tag, "_addr"}, {24'd0, bus.addr}, {24'd0, v.exp_addr});
        chk({tag, "_pc"}, {24'd0, pc_out}, {24'd0, v.exp_addr});
        chk({tag, "_halted"}, {31'd0, halted}, {31'd0, v.exp_halt});
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, !v.exp_halt});
        chk({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    vec_t vec [13];

    initial begin
        //          pc     op     oper   z     cyc exp    issue halt
        vec[0]  = '{8'd0,   8'd8,  8'd0,  1'b0, 3, 8'd1,   1'b1, 1'b0};
        vec[1]  = '{8'd12,  8'd38, 8'd0,  1'b1, 2, 8'd12,  1'b0, 1'b1};
        vec[2]  = '{8'd12,  8'd38, 8'd0,  1'b0, 2, 8'd13,  1'b0, 1'b0};
        vec[3]  = '{8'd34,  8'd40, 8'd13, 1'b0, 4, 8'd13,  1'b0, 1'b0};
        vec[4]  = '{8'd34,  8'd40, 8'd13, 1'b1, 4, 8'd36,  1'b0, 1'b0};
        vec[5]  = '{8'd255, 8'd40, 8'd0,  1'b1, 4, 8'd1,   1'b0, 1'b0};
        vec[6]  = '{8'd255, 8'd40, 8'd0,  1'b0, 4, 8'd40,  1'b0, 1'b0};
        vec[7]  = '{8'd254, 8'd40, 8'd77, 1'b1, 4, 8'd0,   1'b0, 1'b0};
        vec[8]  = '{8'd254, 8'd40, 8'd77, 1'b0, 4, 8'd77,  1'b0, 1'b0};
        vec[9]  = '{8'd255, 8'd9,  8'd0,  1'b0, 3, 8'd0,   1'b1, 1'b0};
        vec[10] = '{8'd100, 8'd0,  8'd0,  1'b0, 3, 8'd101, 1'b1, 1'b0};
        vec[11] = '{8'd200, 8'd39, 8'd0,  1'b0, 3, 8'd201, 1'b1, 1'b0};
        vec[12] = '{8'd13,  8'd41, 8'd0,  1'b1, 3, 8'd14,  1'b1, 1'b0};

        bus.z_flag = 1'b0;
        bus.opcode_ready = 1'b0;
        fill_ram(8'd1);

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_addr", {24'd0, bus.addr}, 32'd0);
        chk("rst_pc", {24'd0, pc_out}, 32'd0);
        chk("rst_opcode", {24'd0, bus.opcode_out}, 32'd0);
        chk("rst_valid", {31'd0, bus.opcode_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_no_start", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 13; i++) run_vec(vec[i], i);

        // Straight line 8,9,11 then END with z=1; then restart from HALT
        rst = 1'b1;
        fill_ram(8'd38);
        ram[0] = 8'd8; ram[1] = 8'd9; ram[2] = 8'd11;
        bus.z_flag = 1'b1;
        bus.opcode_ready = 1'b1;
        exp_q.delete();
        stamp_q.delete();
        exp_q.push_back(8'd8); exp_q.push_back(8'd9); exp_q.push_back(8'd11);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_halt("line_halt", 40);
        chk("line_count", stamp_q.size(), 32'd3);
        if (stamp_q.size() == 3) begin
            chk("line_latency", stamp_q[0] - start_cyc, 32'd2);
            chk("line_gap1", stamp_q[1] - stamp_q[0], 32'd3);
            chk("line_gap2", stamp_q[2] - stamp_q[1], 32'd3);
        end
        chk("halt_pc", {24'd0, pc_out}, 32'd3);
        chk("halt_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("halt_stays", {31'd0, halted}, 32'd1);
        exp_q.push_back(8'd8); exp_q.push_back(8'd9); exp_q.push_back(8'd11);
        pulse_start();
        @(negedge clk);
        chk("restart_addr", {24'd0, bus.addr}, 32'd0);
        chk("restart_busy", {31'd0, busy}, 32'd1);
        chk("restart_halted", {31'd0, halted}, 32'd0);
        wait_halt("restart_halt", 40);
        chk("restart_drain", exp_q.size(), 32'd0);

        // Backpressure on opcode 9
        rst = 1'b1;
        fill_ram(8'd38);
        ram[0] = 8'd8; ram[1] = 8'd9;
        bus.z_flag = 1'b1;
        bus.opcode_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'd8); exp_q.push_back(8'd9);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_valid("bp_first", 8'd8, 10);
        @(posedge clk);
        #1 bus.opcode_ready = 1'b0;
        wait_valid("bp_second", 8'd9, 10);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("bp_hold_valid", {31'd0, bus.opcode_valid}, 32'd1);
            chk("bp_hold_opcode", {24'd0, bus.opcode_out}, 32'd9);
            chk("bp_hold_pc", {24'd0, pc_out}, 32'd1);
        end
        chk("bp_not_accepted", exp_q.size(), 32'd1);
        @(posedge clk);
        #1 bus.opcode_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_after_pc", {24'd0, pc_out}, 32'd2);
        chk("bp_after_valid", {31'd0, bus.opcode_valid}, 32'd0);
        wait_halt("bp_halt", 20);
        chk("bp_drain", exp_q.size(), 32'd0);

        // Asynchronous reset while opcode 9 is pending
        rst = 1'b1;
        fill_ram(8'd38);
        ram[0] = 8'd8; ram[1] = 8'd9;
        bus.opcode_ready = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'd8); exp_q.push_back(8'd9);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_start();
        wait_valid("ar_first", 8'd8, 10);
        @(posedge clk);
        #1 bus.opcode_ready = 1'b0;
        wait_valid("ar_second", 8'd9, 10);
        chk("ar_pre_addr", {24'd0, bus.addr}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", {31'd0, bus.opcode_valid}, 32'd0);
        chk("ar_addr", {24'd0, bus.addr}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        bus.opcode_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("ar_idle_busy", {31'd0, busy}, 32'd0);
        chk("ar_idle_addr", {24'd0, bus.addr}, 32'd0);
        chk("ar_idle_valid", {31'd0, bus.opcode_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

endmodule
